tt_um_serial_subtractor: RTL and testbench
==========================================

// Module: tt_um_serial_subtractor
// PURPOSE
//  Bit-serial 4-bit subtractor. It computes D = A - B LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flop.
//  Companion to the combinational half-adder tile. It shares the standard TT user-tile pinout and sits directly under the TT mux.
//  Start/busy/done handshake. The result holds until the next start.
// PARAMETERS
//  WIDTH   4   operand width in bits; legal 1..4, because pin mapping caps it at 4
// PORTS
//  clk      in   1  system clock; all flops rise-edge
//  rst_n    in   1  reset, asynchronous, active-low
//  ena      in   1  tile enable; 0 freezes every flop (clock-enable)
//  ui_in    in   8  [3:0]=A operand, [7:4]=B operand
//  uio_in   in   8  [0]=start (level, async source); [7:1] unused
//  uo_out   out  8  [3:0]=D, [4]=borrow_out, [5]=busy, [6]=done, [7]=serial D bit
//  uio_out  out  8  tied 0
//  uio_oe   out  8  tied 0 (all uio are inputs)
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
//  Reset: state=IDLE; A/B shift regs, D, borrow, count, sync flops = 0; uo_out=8'h00.
//  Start sync: uio_in[0] -> s1 -> s2. start_evt = s1 & ~s2 (rising edge only).
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : start_evt -> load a_sr<=A, b_sr<=B, br<=0, cnt<=0; go to SHIFT.
//   SHIFT: d = a0^b0^br; br <= (~a0&b0) | (~(a0^b0)&br);
//          d shifts into acc MSB; a_sr/b_sr shift right; cnt++.
//          When cnt==WIDTH-1: D<=final acc, borrow_out<=final br; go to DONE.
//   DONE : done=1; start_evt -> reload as in IDLE; go to SHIFT (done drops).
//  Latency: load on edge cycle L. Bits are processed on L+1..L+WIDTH. D/borrow/done become valid after edge L+WIDTH.
//  busy=1 exactly while in SHIFT. done=1 exactly while in DONE.
//  uo_out[7] = d in SHIFT, 0 otherwise.
//  Arithmetic: D = (A - B) mod 2^WIDTH; borrow_out = (A < B), unsigned.
//  D and borrow_out hold their last values through IDLE/SHIFT. They update only on SHIFT->DONE.
//  start_evt during SHIFT: ignored, with no restart and no queueing.
//  A/B changing during SHIFT: no effect, because operands are captured at load.
//  Level start held high: one event only. A new start needs a low then high transition.
//  ena=0 at any point: all state frozen, outputs hold. Resume on ena=1 with no lost bit.
//  rst_n low mid-SHIFT: immediate abort to reset values; done is not asserted.
//  WIDTH<4: unused D/A/B bits read as 0.
//  uio_out, uio_oe: constant 0. ui_in/uio_in bits not listed above are ignored.
// TESTING
//  1 A=9,B=5, pulse start -> busy 4 cycles, then D=4, borrow=0, done=1; uo_out=8'h44.
//  2 A=5,B=9 -> D=4'hC, borrow=1, done=1; serial bits on [7] in order 0,0,1,1.
//  3 A=0,B=0 and A=15,B=15 -> D=0, borrow=0. Also A=0,B=1 -> D=4'hF, borrow=1.
//  4 Second start pulse in mid-SHIFT with new A/B -> ignored; result equals the first operands.
//     Then hold start high and run a new op -> exactly one run.
//  5 ena=0 for 3 cycles mid-SHIFT -> busy/[7] frozen; done appears 3 cycles late with the correct D.
//  6 rst_n low mid-SHIFT -> uo_out=0 immediately. After release, IDLE with done=0.
//     A fresh start gives the correct result. Random sweep of all 256 A/B pairs matches the model.

Source files
------------

// File: rtl/tt_um_serial_subtractor.sv
// ============================================================================
// tt_um_serial_subtractor : bit-serial A-B through one full-subtractor cell
// Revision: 1.0
// ============================================================================
`default_nettype none

module tt_um_serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [1:0] LAST_CNT = 2'(WIDTH - 1);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             s1;
   logic             s2;
   logic             start_evt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] d_res;
   logic [3:0]       d_ext;
   logic             br;
   logic             br_next;
   logic             borrow_out;
   logic [1:0]       cnt;
   logic             last_bit;
   logic             diff_bit;
   logic             busy;
   logic             done;
   logic             serial_bit;
   logic             load;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             unused_ok;

   assign a_in      = ui_in[WIDTH-1:0];
   assign b_in      = ui_in[4 +: WIDTH];
   assign start_evt = s1 & ~s2;
   assign last_bit  = (cnt == LAST_CNT);

   // Full-subtractor cell: difference bit and borrow into the next bit.
   assign diff_bit = a_sr[0] ^ b_sr[0] ^ br;
   assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

   generate
      if (WIDTH == 1) begin : g_acc_one
         assign acc_next = diff_bit;
      end else begin : g_acc_multi
         assign acc_next = {diff_bit, acc[WIDTH-1:1]};
      end
   endgenerate

   generate
      if (WIDTH < 4) begin : g_pad
         assign d_ext = {{(4 - WIDTH){1'b0}}, d_res};
      end else begin : g_nopad
         assign d_ext = d_res;
      end
   endgenerate

   // State register (ena acts as a clock enable for every flop)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (ena) begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start_evt) state_next = ST_SHIFT;
         ST_SHIFT: if (last_bit)  state_next = ST_DONE;
         ST_DONE:  if (start_evt) state_next = ST_SHIFT;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == ST_SHIFT);
      done       = (state == ST_DONE);
      serial_bit = busy & diff_bit;
      load       = start_evt & (state != ST_SHIFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         a_sr       <= '0;
         b_sr       <= '0;
         acc        <= '0;
         d_res      <= '0;
         br         <= 1'b0;
         borrow_out <= 1'b0;
         cnt        <= 2'd0;
      end else if (ena) begin
         s1 <= uio_in[0];
         s2 <= s1;
         if (load) begin
            a_sr <= a_in;
            b_sr <= b_in;
            acc  <= '0;
            br   <= 1'b0;
            cnt  <= 2'd0;
         end else if (busy) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            acc  <= acc_next;
            br   <= br_next;
            cnt  <= cnt + 2'd1;
            if (last_bit) begin
               d_res      <= acc_next;
               borrow_out <= br_next;
            end
         end
      end
   end

   assign uo_out    = {serial_bit, done, busy, borrow_out, d_ext};
   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;
   assign unused_ok = &{1'b0, uio_in[7:1], ui_in};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_serial_subtractor.sv
// ============================================================================
// tb_tt_um_serial_subtractor : scoreboard bench for the serial subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tt_um_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vectors = 0;
   int miscompares = 0;

   logic [4:0] exp_q[$];
   logic       bit_q[$];
   logic [4:0] last_res;

   tt_um_serial_subtractor #(.WIDTH(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Raises start, pushes the reference result; returns at the negedge just after the load edge.
   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit hold);
      logic [3:0] d;
      d = a - b;
      @(negedge clk);
      ui_in     = {b, a};
      uio_in[0] = 1'b1;
      exp_q.push_back({(a < b), d});
      for (int i = 0; i < 4; i++) bit_q.push_back(d[i]);
      @(negedge clk);
      @(negedge clk);
      if (!hold) uio_in[0] = 1'b0;
   endtask

   task automatic wait_check(input int exp_busy, input string tag);
      int         busy_n;
      bit         seen;
      logic       exp_b;
      logic [4:0] exp_r;
      busy_n = 0;
      seen   = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (uo_out[6]) begin
            seen = 1;
            break;
         end
         if (uo_out[5]) begin
            busy_n++;
            exp_b = (bit_q.size() > 0) ? bit_q[0] : 1'bx;
            vectors++;
            if (uo_out[7] !== exp_b) begin
               miscompares++;
               $display("FAIL %s serial bit %0d: got %b want %b", tag, busy_n, uo_out[7], exp_b);
            end
            vectors++;
            if (uo_out[4:0] !== last_res) begin
               miscompares++;
               $display("FAIL %s held result: got %h want %h", tag, uo_out[4:0], last_res);
            end
            if (ena && bit_q.size() > 0) void'(bit_q.pop_front());
         end
         @(negedge clk);
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s done timeout: got done=0 want done=1", tag);
      end
      vectors++;
      if (busy_n != exp_busy) begin
         miscompares++;
         $display("FAIL %s busy cycles: got %0d want %0d", tag, busy_n, exp_busy);
      end
      exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bx;
      vectors++;
      if (uo_out !== {3'b010, exp_r}) begin
         miscompares++;
         $display("FAIL %s result: got %h want %h", tag, uo_out, {3'b010, exp_r});
      end
      last_res = exp_r;
      bit_q.delete();
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      last_res = 5'h00;
      repeat (3) @(negedge clk);
      vectors++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
         miscompares++;
         $display("FAIL reset outputs: got %h/%h/%h want 00/00/00", uo_out, uio_out, uio_oe);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (uo_out !== 8'h00) begin
         miscompares++;
         $display("FAIL idle after reset: got %h want 00", uo_out);
      end
   endtask

   task automatic test_basic();
      do_op(4'd9, 4'd5, 0);
      wait_check(4, "9-5");
      vectors++;
      if (uo_out !== 8'h44) begin
         miscompares++;
         $display("FAIL 9-5 pinout: got %h want 44", uo_out);
      end
      do_op(4'd5, 4'd9, 0);
      wait_check(4, "5-9");
   endtask

   task automatic test_edges();
      do_op(4'd0, 4'd0, 0);
      wait_check(4, "0-0");
      do_op(4'd15, 4'd15, 0);
      wait_check(4, "15-15");
      do_op(4'd0, 4'd1, 0);
      wait_check(4, "0-1");
   endtask

   task automatic test_ignore_start();
      do_op(4'd11, 4'd6, 0);
      fork
         wait_check(4, "ignore");
         begin
            @(negedge clk);
            @(negedge clk);
            ui_in     = {4'd14, 4'd2};
            uio_in[0] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            uio_in[0] = 1'b0;
         end
      join
      do_op(4'd3, 4'd7, 1);
      wait_check(4, "held start");
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vectors++;
         if (uo_out[5] !== 1'b0 || uo_out[6] !== 1'b1) begin
            miscompares++;
            $display("FAIL held start rerun: got busy=%b done=%b want 0/1", uo_out[5], uo_out[6]);
         end
      end
      uio_in[0] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ena_freeze();
      do_op(4'd13, 4'd6, 0);
      fork
         wait_check(7, "ena freeze");
         begin
            @(negedge clk);
            @(negedge clk);
            ena = 1'b0;
            repeat (3) @(negedge clk);
            ena = 1'b1;
         end
      join
   endtask

   task automatic test_reset_abort();
      do_op(4'd12, 4'd3, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (uo_out !== 8'h00) begin
         miscompares++;
         $display("FAIL async abort: got %h want 00", uo_out);
      end
      void'(exp_q.pop_front());
      bit_q.delete();
      last_res = 5'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if (uo_out !== 8'h00) begin
         miscompares++;
         $display("FAIL idle after abort: got %h want 00", uo_out);
      end
      do_op(4'd12, 4'd3, 0);
      wait_check(4, "after abort");
   endtask

   task automatic test_sweep();
      int off;
      int idx;
      off = int'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) begin
         idx = (off + i * 37) % 256;
         do_op(4'(idx), 4'(idx >> 4), 0);
         wait_check(4, "sweep");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_ignore_start();
      test_ena_freeze();
      test_reset_abort();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
